seven_seg_scan_ctrl: RTL and testbench

//  Converts a binary result (e.g. multiplier product) to 4 BCD digits by sequential

---
 rtl/seven_seg_scan_ctrl.sv | 134 +++++++++++++
 tb/tb_seven_seg_scan_ctrl.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/seven_seg_scan_ctrl.sv
// Binary-to-BCD converter (sequential double-dabble) with a held result that is
// time-multiplexed onto a 4-digit 7-segment decoder, with leading-zero blanking and overflow.
module seven_seg_scan_ctrl #(
  parameter int DATA_W      = 14,
  parameter int REFRESH_DIV = 100000,
  parameter int LZ_BLANK    = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_valid,
  input  logic [DATA_W-1:0] load_data,
  output logic              load_ready,
  output logic              ovf,
  output logic [1:0]        digit_sel,
  output logic [3:0]        digit_num
);

  localparam int STEP_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam int PRE_W  = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

  typedef enum logic {IDLE, CONVERT} state_t;

  state_t             state_reg, state_next;
  logic [DATA_W-1:0]  shift_reg, shift_next;
  logic [15:0]        work_reg, work_next, work_adj;
  logic [STEP_W-1:0]  step_reg, step_next;
  logic [15:0]        bcd_reg, bcd_next;
  logic               ovf_reg, ovf_next;
  logic [PRE_W-1:0]   pre_reg;
  logic [1:0]         sel_reg;
  logic               over_max;

  // Add-3 correction on every nibble that would overflow a decimal digit after the shift
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_adj
      assign work_adj[gi*4 +: 4] = (work_reg[gi*4 +: 4] >= 4'd5) ?
                                   work_reg[gi*4 +: 4] + 4'd3 : work_reg[gi*4 +: 4];
    end
  endgenerate

  assign over_max = {{(16-DATA_W){1'b0}}, load_data} > 16'd9999;

  always_comb begin
    state_next = state_reg;
    shift_next = shift_reg;
    work_next  = work_reg;
    step_next  = step_reg;
    bcd_next   = bcd_reg;
    ovf_next   = ovf_reg;
    load_ready = 1'b0;
    case (state_reg)
      IDLE: begin
        load_ready = 1'b1;
        if (load_valid) begin
          if (over_max) begin
            ovf_next = 1'b1;
          end else begin
            shift_next = load_data;
            work_next  = '0;
            step_next  = '0;
            state_next = CONVERT;
          end
        end
      end
      CONVERT: begin
        work_next  = (work_adj << 1) | {15'd0, shift_reg[DATA_W-1]};
        shift_next = shift_reg << 1;
        step_next  = step_reg + 1'b1;
        // Last step: the stored value and ovf update together so the display never tears
        if (step_reg == STEP_W'(DATA_W-1)) begin
          bcd_next   = work_next;
          ovf_next   = 1'b0;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      shift_reg <= '0;
      work_reg  <= '0;
      step_reg  <= '0;
      bcd_reg   <= '0;
      ovf_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      shift_reg <= shift_next;
      work_reg  <= work_next;
      step_reg  <= step_next;
      bcd_reg   <= bcd_next;
      ovf_reg   <= ovf_next;
    end
  end

  // Free-running scan, independent of the conversion FSM
  always_ff @(posedge clk) begin
    if (rst) begin
      pre_reg <= '0;
      sel_reg <= 2'd0;
    end else if (pre_reg == PRE_W'(REFRESH_DIV-1)) begin
      pre_reg <= '0;
      sel_reg <= sel_reg + 2'd1;
    end else begin
      pre_reg <= pre_reg + 1'b1;
    end
  end

  logic d3_zero, d2_zero, d1_zero, blank;

  assign d3_zero = (bcd_reg[15:12] == 4'd0);
  assign d2_zero = (bcd_reg[11:8]  == 4'd0);
  assign d1_zero = (bcd_reg[7:4]   == 4'd0);

  always_comb begin
    blank = 1'b0;
    case (sel_reg)
      2'd3:    blank = d3_zero;
      2'd2:    blank = d3_zero && d2_zero;
      2'd1:    blank = d3_zero && d2_zero && d1_zero;
      default: blank = 1'b0;
    endcase
    if (ovf_reg || ((LZ_BLANK != 0) && blank))
      digit_num = 4'hF;
    else
      digit_num = bcd_reg[sel_reg*4 +: 4];
  end

  assign ovf       = ovf_reg;
  assign digit_sel = sel_reg;

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Directed bench for seven_seg_scan_ctrl: table of loads with hand-computed digit slots,
// plus sequences for reset scan, ignored loads during conversion and reset mid-conversion.
module tb_seven_seg_scan_ctrl;

  localparam int DW = 14;
  localparam int RD = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          load_valid;
  logic [DW-1:0] load_data;
  logic          load_ready;
  logic          ovf;
  logic [1:0]    digit_sel;
  logic [3:0]    digit_num;

  seven_seg_scan_ctrl #(.DATA_W(DW), .REFRESH_DIV(RD), .LZ_BLANK(1)) dut (
    .clk(clk), .rst(rst), .load_valid(load_valid), .load_data(load_data),
    .load_ready(load_ready), .ovf(ovf), .digit_sel(digit_sel), .digit_num(digit_num)
  );

  always #5 clk = ~clk;

  int pass_cnt  = 0;
  int total_cnt = 0;

  typedef struct {
    logic [DW-1:0] data;
    logic [15:0]   exp_digits;  // {slot3, slot2, slot1, slot0}
    logic          exp_ovf;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic fail_now(input string name);
    total_cnt++;
    $display("FAIL %s: timed out waiting for DUT", name);
  endtask

  // Caller is at a negedge; walk through each slot and compare the digit shown there
  task automatic check_slots(input string name, input logic [15:0] exp);
    for (int k = 0; k < 4; k++) begin
      int n = 0;
      while (digit_sel != 2'(k) && n < 4*RD+4) begin
        @(negedge clk);
        n++;
      end
      if (digit_sel != 2'(k)) fail_now($sformatf("%s_slot%0d", name, k));
      else check($sformatf("%s_slot%0d", name, k), 32'(digit_num), 32'(exp[k*4 +: 4]));
    end
  endtask

  // Returns one time unit after the accepting edge T, i.e. inside cycle T+1
  task automatic do_load(input logic [DW-1:0] v);
    int n = 0;
    @(negedge clk);
    while (!load_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!load_ready) fail_now("load_wait_ready");
    load_valid = 1'b1;
    load_data  = v;
    @(posedge clk);
    #1;
    load_valid = 1'b0;
    load_data  = '0;
  endtask

  task automatic check_latency(input string name);
    int bad = 0;
    for (int i = 1; i <= DW; i++) begin
      @(negedge clk);
      if (load_ready !== 1'b0) bad++;
    end
    check({name, "_busy_cycles_ready"}, 32'(bad), 32'd0);
    @(negedge clk);
    check({name, "_ready_at_T15"}, 32'(load_ready), 32'd1);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int bad;
    int cyc;
    logic [15:0] old_disp;

    vecs[0] = '{14'd1234,  16'h1234, 1'b0};
    vecs[1] = '{14'd7,     16'hFFF7, 1'b0};
    vecs[2] = '{14'd0,     16'hFFF0, 1'b0};
    vecs[3] = '{14'd1005,  16'h1005, 1'b0};
    vecs[4] = '{14'd9999,  16'h9999, 1'b0};
    vecs[5] = '{14'd10000, 16'hFFFF, 1'b1};

    rst = 1'b1; load_valid = 1'b0; load_data = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state and scan cadence: digit_sel advances every RD cycles and wraps
    @(negedge clk);
    check("rst_ready", 32'(load_ready), 32'd1);
    check("rst_ovf", 32'(ovf), 32'd0);
    check("rst_sel", 32'(digit_sel), 32'd0);
    check("rst_num", 32'(digit_num), 32'd0);
    bad = 0;
    for (int i = 0; i <= 16; i++) begin
      if (i > 0) @(negedge clk);
      if (digit_sel != 2'((i / RD) % 4)) bad++;
    end
    check("scan_cadence", 32'(bad), 32'd0);
    check("scan_wrap", 32'(digit_sel), 32'd0);

    for (int v = 0; v < 6; v++) begin
      do_load(vecs[v].data);
      if (vecs[v].exp_ovf) begin
        @(negedge clk);
        check($sformatf("v%0d_ready_ovf", vecs[v].data), 32'(load_ready), 32'd1);
      end else begin
        check_latency($sformatf("v%0d", vecs[v].data));
      end
      check($sformatf("v%0d_ovf", vecs[v].data), 32'(ovf), 32'(vecs[v].exp_ovf));
      check_slots($sformatf("v%0d", vecs[v].data), vecs[v].exp_digits);
    end

    // Load during CONVERT is dropped; display holds the old value until commit
    do_load(14'd42);
    check_latency("v42");
    check_slots("v42", 16'hFF42);
    old_disp = 16'hFF42;
    do_load(14'd1234);
    bad = 0;
    repeat (2) begin
      @(negedge clk);
      if (digit_num !== old_disp[digit_sel*4 +: 4]) bad++;
    end
    @(negedge clk);
    if (digit_num !== old_disp[digit_sel*4 +: 4]) bad++;
    load_valid = 1'b1;
    load_data  = 14'd5678;
    @(posedge clk);
    #1;
    load_valid = 1'b0;
    load_data  = '0;
    cyc = 3;
    while (cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (load_ready) break;
      if (digit_num !== old_disp[digit_sel*4 +: 4]) bad++;
    end
    check("ign_old_display_held", 32'(bad), 32'd0);
    check("ign_commit_cycle", 32'(cyc), 32'd15);
    check_slots("ign_1234", 16'h1234);
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (!load_ready) bad++;
    end
    check("ign_no_second_conv", 32'(bad), 32'd0);
    check_slots("ign_1234_again", 16'h1234);

    // Reset mid-conversion: back to reset values, 4321 never reaches the display
    old_disp = 16'h1234;
    do_load(14'd4321);
    bad = 0;
    repeat (5) begin
      @(negedge clk);
      if (digit_num !== old_disp[digit_sel*4 +: 4]) bad++;
    end
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("abort_old_display", 32'(bad), 32'd0);
    check("abort_ready", 32'(load_ready), 32'd1);
    check("abort_ovf", 32'(ovf), 32'd0);
    check("abort_sel", 32'(digit_sel), 32'd0);
    check("abort_num", 32'(digit_num), 32'd0);
    old_disp = 16'hFFF0;
    bad = 0;
    repeat (40) begin
      @(negedge clk);
      if (digit_num !== old_disp[digit_sel*4 +: 4] || !load_ready) bad++;
    end
    check("abort_stays_blank", 32'(bad), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
